// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_param
// Description : Parametrised UART transmitter. Serialises start, DATA_W data
//               bits (LSB first), optional parity and 1/2 stop bits at a fixed
//               baud divisor, fed by a valid/ready handshake.
//               Optional macro UART_TX_FIFO_EN adds a FIFO_DEPTH-entry FIFO
//               in front of the FSM and exposes the fifo_level port.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              serial_output,
  output logic              busy
`ifdef UART_TX_FIFO_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`endif
);

  localparam int c_timer_w = (CLKS_PER_BIT >= 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_timer_w-1:0] c_last_tick = c_timer_w'(CLKS_PER_BIT - 1);
  localparam logic [3:0] c_last_data = 4'(DATA_W - 1);
  localparam logic [3:0] c_last_stop = 4'(STOP_BITS - 1);

  // Reject configurations the frame logic cannot represent
  if ((DATA_W < 5) || (DATA_W > 9)) begin : g_bad_data_w
    $error("uart_tx_param: DATA_W must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if ((PARITY_MODE < 0) || (PARITY_MODE > 2)) begin : g_bad_parity
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of 2 >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_timer_w-1:0]  r_timer;
  logic [3:0]            r_bitcnt;
  logic [DATA_W-1:0]     r_shift;
  logic                  r_par;
  logic                  r_tx;

  logic                  w_bit_end;
  logic                  w_last_stop;
  logic                  w_load;
  logic [DATA_W-1:0]     w_load_data;
  logic                  w_par;

  assign w_bit_end   = (r_timer == c_last_tick);
  // Final cycle of the last stop bit: a new word may start the next cycle
  assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_bitcnt == c_last_stop);
  assign w_par       = (PARITY_MODE == 2) ? ~^w_load_data : ^w_load_data;
  assign serial_output = r_tx;

`ifdef UART_TX_FIFO_EN
  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0] c_depth = (c_aw + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_level;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  assign w_full      = (r_level == c_depth);
  assign w_empty     = (r_level == '0);
  assign w_push      = tx_valid && !w_full;
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || w_last_stop);
  assign tx_ready    = !w_full;
  assign w_load      = w_pop;
  assign w_load_data = r_mem[r_rd_ptr];
  assign busy        = (r_state != S_IDLE) || !w_empty;
  assign fifo_level  = r_level;

  // FIFO storage; contents need no reset because the level guards reads
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
`else
  // Single-word mode: also ready in the final stop cycle so a held word
  // follows the previous frame with no idle gap
  assign tx_ready    = (r_state == S_IDLE) || w_last_stop;
  assign w_load      = tx_valid && tx_ready;
  assign w_load_data = tx_data;
  assign busy        = (r_state != S_IDLE);
`endif

  // Frame sequencer: bit timer, bit counter, shift register and registered line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_timer <= r_timer + c_timer_w'(1);
      if (w_load) begin
        r_state  <= S_START;
        r_timer  <= '0;
        r_bitcnt <= '0;
        r_shift  <= w_load_data;
        r_par    <= w_par;
        r_tx     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_timer <= '0;
            r_tx    <= 1'b1;
          end
          S_START: begin
            if (w_bit_end) begin
              r_state  <= S_DATA;
              r_timer  <= '0;
              r_bitcnt <= '0;
              r_tx     <= r_shift[0];
            end
          end
          S_DATA: begin
            if (w_bit_end) begin
              r_timer <= '0;
              if (r_bitcnt == c_last_data) begin
                r_bitcnt <= '0;
                if (PARITY_MODE != 0) begin
                  r_state <= S_PARITY;
                  r_tx    <= r_par;
                end else begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
                end
              end else begin
                r_bitcnt <= r_bitcnt + 4'd1;
                r_shift  <= r_shift >> 1;
                r_tx     <= r_shift[1];
              end
            end
          end
          S_PARITY: begin
            if (w_bit_end) begin
              r_state  <= S_STOP;
              r_timer  <= '0;
              r_bitcnt <= '0;
              r_tx     <= 1'b1;
            end
          end
          S_STOP: begin
            if (w_bit_end) begin
              r_timer <= '0;
              if (r_bitcnt == c_last_stop) begin
                r_state  <= S_IDLE;
                r_bitcnt <= '0;
                r_tx     <= 1'b1;
              end else begin
                r_bitcnt <= r_bitcnt + 4'd1;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_param
// Description : Directed self-checking bench for uart_tx_param (4 clk/bit).
//               Three instances cover even parity, odd parity and no-parity
//               with two stop bits. Define UART_TX_FIFO_EN to exercise the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_param;

`ifdef UART_TX_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] v = 3'b000;
  logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00;
  logic       line0, line1, line2;
  logic       b0, b1, b2;
  logic       y0, y1, y2;
`ifdef UART_TX_FIFO_EN
  logic [2:0] lv0, lv1, lv2;
`endif

  int checks = 0;
  int failures = 0;

  logic [10:0] fe, fo, fn, ftmp;
  logic [7:0]  w6 [5];
  logic [10:0] fr6 [5];

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
    .clk(clk), .reset(reset), .tx_valid(v[0]), .tx_data(d0), .tx_ready(y0),
    .serial_output(line0), .busy(b0)
`ifdef UART_TX_FIFO_EN
    , .fifo_level(lv0)
`endif
  );

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
    .clk(clk), .reset(reset), .tx_valid(v[1]), .tx_data(d1), .tx_ready(y1),
    .serial_output(line1), .busy(b1)
`ifdef UART_TX_FIFO_EN
    , .fifo_level(lv1)
`endif
  );

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_np2 (
    .clk(clk), .reset(reset), .tx_valid(v[2]), .tx_data(d2), .tx_ready(y2),
    .serial_output(line2), .busy(b2)
`ifdef UART_TX_FIFO_EN
    , .fifo_level(lv2)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_line0"}, 16'(line0), 16'd1);
    chk({tag, "_busy0"}, 16'(b0), 16'd0);
    chk({tag, "_ready0"}, 16'(y0), 16'd1);
    chk({tag, "_line1"}, 16'(line1), 16'd1);
    chk({tag, "_busy1"}, 16'(b1), 16'd0);
    chk({tag, "_line2"}, 16'(line2), 16'd1);
    chk({tag, "_busy2"}, 16'(b2), 16'd0);
`ifdef UART_TX_FIFO_EN
    chk({tag, "_level0"}, 16'(lv0), 16'd0);
`endif
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-computed frames, bit i sent i-th: {stop, parity, data[7:0], start}
    fe = 11'b10101001010;   // 0xA5 even parity -> parity 0
    fo = 11'b11101001010;   // 0xA5 odd parity  -> parity 1
    fn = 11'b11000000000;   // 0x00 no parity, two stop bits

    // T1: reset held, then asserted asynchronously mid-run
    repeat (3) @(negedge clk);
    chk_idle("t1_held");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_idle("t1_async");
    @(negedge clk);
    chk_idle("t1_async_held");
    reset = 1'b0;
    @(negedge clk);

    // T2/T3: 0xA5 even, 0xA5 odd, 0x00 no-parity 2-stop, started together
    d0 = 8'hA5; d1 = 8'hA5; d2 = 8'h00; v = 3'b111;
    @(negedge clk);
    v = 3'b000;
    d0 = 8'h5A; d1 = 8'h5A; d2 = 8'hFF;   // must not affect frames in flight
    chk("t2_busy_after_accept", 16'(b0), 16'd1);
    repeat (LAT) @(negedge clk);
    for (int k = 0; k < 44; k++) begin
      chk($sformatf("t2_even_c%0d", k), 16'(line0), 16'(fe[k/4]));
      chk($sformatf("t2_odd_c%0d", k), 16'(line1), 16'(fo[k/4]));
      chk($sformatf("t3_np2_c%0d", k), 16'(line2), 16'(fn[k/4]));
      if (k == 43) begin
        chk("t2_busy_last_stop", 16'(b0), 16'd1);
        chk("t3_busy_last_stop", 16'(b2), 16'd1);
      end
      @(negedge clk);
    end
    chk_idle("t2_cycle45");

`ifndef UART_TX_FIFO_EN
    // T4: tx_valid held, 0x01 then 0x80, no idle cycle between frames
    fe = 11'b11000000010;   // 0x01 even -> parity 1
    fo = 11'b11100000000;   // 0x80 even -> parity 1
    d0 = 8'h01; v[0] = 1'b1;
    @(negedge clk);
    d0 = 8'h80;
    for (int k = 0; k < 44; k++) begin
      chk($sformatf("t4_w01_c%0d", k), 16'(line0), 16'(fe[k/4]));
      if (k == 20) chk("t4_ready_mid", 16'(y0), 16'd0);
      if (k == 43) chk("t4_ready_last_stop", 16'(y0), 16'd1);
      @(negedge clk);
    end
    v[0] = 1'b0;
    for (int k = 0; k < 44; k++) begin
      chk($sformatf("t4_w80_c%0d", k), 16'(line0), 16'(fo[k/4]));
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      chk_idle($sformatf("t4_after_%0d", k));
      @(negedge clk);
    end
`endif

    // T5: reset during data bit 3 of 0xFF, then a clean 0x3C frame
    d0 = 8'hFF; v[0] = 1'b1;
    @(negedge clk);
    v[0] = 1'b0;
    repeat (LAT) @(negedge clk);
    repeat (17) @(negedge clk);
    chk("t5_busy_before_reset", 16'(b0), 16'd1);
    #2 reset = 1'b1;
    #1 chk_idle("t5_reset_now");
    @(negedge clk);
    chk_idle("t5_reset_held");
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("t5_abandon_line_c%0d", k), 16'(line0), 16'd1);
      chk($sformatf("t5_abandon_busy_c%0d", k), 16'(b0), 16'd0);
    end
    fe = 11'b10001111000;   // 0x3C even -> parity 0
    d0 = 8'h3C; v[0] = 1'b1;
    @(negedge clk);
    v[0] = 1'b0;
    repeat (LAT) @(negedge clk);
    for (int k = 0; k < 44; k++) begin
      chk($sformatf("t5_w3c_c%0d", k), 16'(line0), 16'(fe[k/4]));
      @(negedge clk);
    end
    chk_idle("t5_done");

`ifdef UART_TX_FIFO_EN
    // T6: five back-to-back pushes into a depth-4 FIFO
    w6[0] = 8'h11; fr6[0] = 11'b10000100010;
    w6[1] = 8'h22; fr6[1] = 11'b10001000100;
    w6[2] = 8'h37; fr6[2] = 11'b11001101110;
    w6[3] = 8'h48; fr6[3] = 11'b10010010000;
    w6[4] = 8'hF0; fr6[4] = 11'b10111100000;
    d0 = w6[0]; v[0] = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= 221; c++) begin
      if (c >= 1 && c <= 220) begin
        ftmp = fr6[(c-1)/44];
        chk($sformatf("t6_line_c%0d", c), 16'(line0), 16'(ftmp[((c-1)%44)/4]));
      end
      case (c)
        0:   begin chk("t6_lvl_c0", 16'(lv0), 16'd1); d0 = w6[1]; end
        1:   begin chk("t6_lvl_c1", 16'(lv0), 16'd1); d0 = w6[2]; end
        2:   begin chk("t6_lvl_c2", 16'(lv0), 16'd2); d0 = w6[3]; end
        3:   begin chk("t6_lvl_c3", 16'(lv0), 16'd3); d0 = w6[4]; end
        4:   begin chk("t6_lvl_c4", 16'(lv0), 16'd4); chk("t6_full_c4", 16'(y0), 16'd0); end
        44:  begin chk("t6_lvl_c44", 16'(lv0), 16'd4); chk("t6_full_c44", 16'(y0), 16'd0); end
        45:  begin chk("t6_lvl_c45", 16'(lv0), 16'd3); chk("t6_ready_c45", 16'(y0), 16'd1); end
        46:  begin chk("t6_lvl_c46", 16'(lv0), 16'd4); v[0] = 1'b0; end
        221: chk_idle("t6_done");
        default: ;
      endcase
      if (c < 221) @(negedge clk);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
